// File: rtl/apb_cmd_pkg.sv
// ============================================================================
// apb_cmd_pkg - shared types and default widths for the APB command master
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package apb_cmd_pkg;

    localparam int ADDR_WD_DEF = 32;
    localparam int DATA_WD_DEF = 32;
    localparam int STRB_WD_DEF = 4;
    localparam int PROT_WD_DEF = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    typedef struct packed {
        logic                   write;
        logic [ADDR_WD_DEF-1:0] addr;
        logic [DATA_WD_DEF-1:0] wdata;
        logic [STRB_WD_DEF-1:0] strb;
        logic [PROT_WD_DEF-1:0] prot;
    } cmd_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_cmd_fifo.sv
// ============================================================================
// apb_cmd_fifo - synchronous command FIFO with full/empty flags
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module apb_cmd_fifo
    import apb_cmd_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type ENTRY_T = cmd_t
) (
    input  logic   a_pclk,
    input  logic   a_prst_n,
    input  logic   push,
    input  ENTRY_T push_data,
    input  logic   pop,
    output ENTRY_T head,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("apb_cmd_fifo: DEPTH must be a power of 2 and >= 2");
    end

    ENTRY_T        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // The extra pointer bit separates full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge a_pclk or negedge a_prst_n) begin
        if (!a_prst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge a_pclk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_cmd_master.sv
// ============================================================================
// apb_cmd_master - FIFO-buffered APB master, one in-order response per command
// Optional macro APB_TIMEOUT_EN: abort a stalled ACCESS after TMO_CYC cycles.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module apb_cmd_master
    import apb_cmd_pkg::*;
#(
    parameter int ADDR_WD = ADDR_WD_DEF,
    parameter int DATA_WD = DATA_WD_DEF,
    parameter int STRB_WD = STRB_WD_DEF,
    parameter int PROT_WD = PROT_WD_DEF,
    parameter int DEPTH   = 4,
    parameter int TMO_CYC = 255
) (
    input  logic               a_pclk,
    input  logic               a_prst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDR_WD-1:0] cmd_addr,
    input  logic [DATA_WD-1:0] cmd_wdata,
    input  logic [STRB_WD-1:0] cmd_strb,
    input  logic [PROT_WD-1:0] cmd_prot,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_WD-1:0] rsp_rdata,
    output logic               rsp_write,
    output logic               rsp_err,
    output logic               a_psel,
    output logic               a_penable,
    output logic               a_pwrite,
    output logic [ADDR_WD-1:0] a_paddr,
    output logic [DATA_WD-1:0] a_pwdata,
    output logic [PROT_WD-1:0] a_pprot,
    output logic [STRB_WD-1:0] a_pstrb,
    input  logic [DATA_WD-1:0] a_prdata,
    input  logic               a_pready,
    output logic               tmo_sticky,
    output logic               busy
);

    if (TMO_CYC < 1) begin : g_tmo_check
        $error("apb_cmd_master: TMO_CYC must be >= 1");
    end

    typedef struct packed {
        logic               write;
        logic [ADDR_WD-1:0] addr;
        logic [DATA_WD-1:0] wdata;
        logic [STRB_WD-1:0] strb;
        logic [PROT_WD-1:0] prot;
    } entry_t;

    entry_t push_data;
    entry_t head;
    logic   fifo_full;
    logic   fifo_empty;
    state_t state;
    state_t state_nxt;
    logic   launch;
    logic   finish;
    logic   abort;

    assign push_data = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata,
                         strb: cmd_strb, prot: cmd_prot};

    apb_cmd_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_T (entry_t)
    ) u_fifo (
        .a_pclk    (a_pclk),
        .a_prst_n  (a_prst_n),
        .push      (cmd_valid),
        .push_data (push_data),
        .pop       (finish),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign cmd_ready = !fifo_full;
    assign a_psel    = (state != IDLE);
    assign a_penable = (state == ACCESS);
    assign busy      = !fifo_empty || (state != IDLE) || rsp_valid;

`ifdef APB_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_flag;

    // tmo_cnt holds the number of ACCESS cycles already spent waiting.
    assign abort      = (state == ACCESS) && !a_pready && (tmo_cnt == TW'(TMO_CYC - 1));
    assign tmo_sticky = tmo_flag;

    always_ff @(posedge a_pclk or negedge a_prst_n) begin
        if (!a_prst_n) begin
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else begin
            if (state != ACCESS) begin
                tmo_cnt <= '0;
            end else if (!a_pready) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            if (abort) begin
                tmo_flag <= 1'b1;
            end
        end
    end
`else
    assign abort      = 1'b0;
    assign tmo_sticky = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !rsp_valid && !tmo_sticky) begin
                    state_nxt = SETUP;
                    launch    = 1'b1;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (a_pready || abort) begin
                    state_nxt = IDLE;
                    finish    = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge a_pclk or negedge a_prst_n) begin
        if (!a_prst_n) begin
            state     <= IDLE;
            a_pwrite  <= 1'b0;
            a_paddr   <= '0;
            a_pwdata  <= '0;
            a_pprot   <= '0;
            a_pstrb   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_write <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                a_pwrite <= head.write;
                a_paddr  <= head.addr;
                a_pwdata <= head.wdata;
                a_pprot  <= head.prot;
                a_pstrb  <= head.strb;
            end
            // A response can only complete while none is pending, so the two never collide.
            if (finish) begin
                rsp_valid <= 1'b1;
                rsp_write <= a_pwrite;
                rsp_err   <= abort;
                rsp_rdata <= (a_pwrite || abort) ? '0 : a_prdata;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: transaction-level model checked every cycle plus directed literals.
`timescale 1ns/1ps
`default_nettype none

module tb_apb_cmd_master;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SW    = 4;
    localparam int PW    = 3;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic          a_pclk    = 1'b0;
    logic          a_prst_n  = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_strb  = '0;
    logic [PW-1:0] cmd_prot  = '0;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] a_prdata  = '0;
    logic          a_pready  = 1'b0;

    logic          cmd_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_write;
    logic          rsp_err;
    logic          a_psel;
    logic          a_penable;
    logic          a_pwrite;
    logic [AW-1:0] a_paddr;
    logic [DW-1:0] a_pwdata;
    logic [PW-1:0] a_pprot;
    logic [SW-1:0] a_pstrb;
    logic          tmo_sticky;
    logic          busy;

    always #5 a_pclk = ~a_pclk;

    apb_cmd_master #(
        .ADDR_WD (AW), .DATA_WD (DW), .STRB_WD (SW), .PROT_WD (PW),
        .DEPTH   (DEPTH), .TMO_CYC (TMO)
    ) dut (
        .a_pclk     (a_pclk),     .a_prst_n  (a_prst_n),
        .cmd_valid  (cmd_valid),  .cmd_ready (cmd_ready),
        .cmd_write  (cmd_write),  .cmd_addr  (cmd_addr),
        .cmd_wdata  (cmd_wdata),  .cmd_strb  (cmd_strb),
        .cmd_prot   (cmd_prot),   .rsp_valid (rsp_valid),
        .rsp_ready  (rsp_ready),  .rsp_rdata (rsp_rdata),
        .rsp_write  (rsp_write),  .rsp_err   (rsp_err),
        .a_psel     (a_psel),     .a_penable (a_penable),
        .a_pwrite   (a_pwrite),   .a_paddr   (a_paddr),
        .a_pwdata   (a_pwdata),   .a_pprot   (a_pprot),
        .a_pstrb    (a_pstrb),    .a_prdata  (a_prdata),
        .a_pready   (a_pready),   .tmo_sticky(tmo_sticky),
        .busy       (busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [PW-1:0] prot;
    } mcmd_t;

    mcmd_t         pend[$];           // accepted, not yet completed (head = in flight)
    int            xfer_age = -1;     // cycles since select rose, -1 when no transfer
    bit            m_rsp    = 1'b0;
    bit            m_write  = 1'b0;
    bit            m_err    = 1'b0;
    bit            m_sticky = 1'b0;
    logic [DW-1:0] m_rdata  = '0;
    logic [AW-1:0] rsp_log[$];        // addresses of completed commands, in completion order

    task automatic model_reset();
        pend.delete();
        xfer_age = -1;
        m_rsp    = 1'b0;
        m_sticky = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs seen at that edge.
    task automatic model_edge();
        bit    push, start, done, tmo;
        mcmd_t c;
        push  = cmd_valid && (pend.size() < DEPTH);
        start = (xfer_age < 0) && (pend.size() > 0) && !m_rsp && !m_sticky;
        done  = (xfer_age >= 1) && a_pready;
        tmo   = 1'b0;
`ifdef APB_TIMEOUT_EN
        tmo   = (xfer_age == TMO) && !a_pready;
`endif
        if (m_rsp && rsp_ready) m_rsp = 1'b0;
        if (done || tmo) begin
            c        = pend.pop_front();
            m_rsp    = 1'b1;
            m_write  = c.write;
            m_err    = tmo;
            m_rdata  = (c.write || tmo) ? '0 : a_prdata;
            rsp_log.push_back(c.addr);
            xfer_age = -1;
            if (tmo) m_sticky = 1'b1;
        end else if (xfer_age >= 0) begin
            xfer_age++;
        end
        if (start) xfer_age = 0;
        if (push) begin
            c.write = cmd_write; c.addr = cmd_addr; c.wdata = cmd_wdata;
            c.strb  = cmd_strb;  c.prot = cmd_prot;
            pend.push_back(c);
        end
    endtask

    task automatic compare_outputs();
        chk("cmd_ready", cmd_ready, pend.size() < DEPTH);
        chk("a_psel", a_psel, xfer_age >= 0);
        chk("a_penable", a_penable, xfer_age >= 1);
        chk("rsp_valid", rsp_valid, m_rsp);
        chk("tmo_sticky", tmo_sticky, m_sticky);
        chk("busy", busy, (pend.size() > 0) || (xfer_age >= 0) || m_rsp);
        if (xfer_age >= 0 && pend.size() > 0) begin
            chk("a_paddr", a_paddr, pend[0].addr);
            chk("a_pwrite", a_pwrite, pend[0].write);
            chk("a_pwdata", a_pwdata, pend[0].wdata);
            chk("a_pstrb", a_pstrb, pend[0].strb);
            chk("a_pprot", a_pprot, pend[0].prot);
        end
        if (m_rsp) begin
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("rsp_write", rsp_write, m_write);
            chk("rsp_err", rsp_err, m_err);
        end
    endtask

    initial begin : compare
        forever begin
            @(negedge a_pclk);
            if (!a_prst_n) model_reset();
            else           model_edge();
            compare_outputs();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge a_pclk);
        #1;
    endtask

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input logic [PW-1:0] p);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        cmd_strb  = s;    cmd_prot  = p;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, input string name);
        int n = 0;
        while (!rsp_valid && n < budget) begin
            step();
            n++;
        end
        if (!rsp_valid) begin
            checks++; failures++;
            $display("FAIL %s: rsp_valid=0 after %0d cycles, required 1", name, budget);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy && n < budget) begin
            a_pready = 1'($urandom_range(0, 1));
            a_prdata = $urandom;
            step();
            n++;
        end
        if (busy) begin
            checks++; failures++;
            $display("FAIL %s: busy=1 after %0d cycles, required 0", name, budget);
        end
    endtask

    task automatic do_reset();
        a_prst_n = 1'b0;
        step();
        step();
        a_prst_n = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int acc;
        int n;
        // reset values
        repeat (3) @(negedge a_pclk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_psel", a_psel, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        a_prst_n = 1'b1;
        step();

        // 1: write with a 4-cycle ACCESS stall
        rsp_ready = 1'b0; a_pready = 1'b0;
        send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'h2);
        chk("t1_psel_e0", a_psel, 1'b0);
        step();
        chk("t1_psel_e1", a_psel, 1'b1);
        chk("t1_pen_e1", a_penable, 1'b0);
        chk("t1_paddr", a_paddr, 32'h10);
        chk("t1_pwdata", a_pwdata, 32'hDEADBEEF);
        step();
        chk("t1_pen_e2", a_penable, 1'b1);
        repeat (4) begin
            step();
            chk("t1_pen_hold", a_penable, 1'b1);
            chk("t1_paddr_hold", a_paddr, 32'h10);
        end
        a_pready = 1'b1;
        step();
        chk("t1_rsp_valid", rsp_valid, 1'b1);
        chk("t1_rsp_write", rsp_write, 1'b1);
        chk("t1_rsp_rdata", rsp_rdata, 32'h0);
        chk("t1_psel_done", a_psel, 1'b0);
        a_pready = 1'b0; rsp_ready = 1'b1;
        step();
        chk("t1_rsp_clear", rsp_valid, 1'b0);

        // 2: read returning data
        rsp_ready = 1'b0; a_pready = 1'b1; a_prdata = 32'h12345678;
        send(1'b0, 32'h20, 32'h0, 4'h0, 3'h0);
        wait_rsp(10, "t2_rsp");
        chk("t2_rdata", rsp_rdata, 32'h12345678);
        chk("t2_err", rsp_err, 1'b0);
        chk("t2_write", rsp_write, 1'b0);
        rsp_ready = 1'b1; a_pready = 1'b0;
        step();

        // 3: FIFO fills, one command rejected, no issue while response is pending
        rsp_log.delete();
        rsp_ready = 1'b0; a_pready = 1'b0; acc = 0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h100 + 32'(4 * i);
            cmd_wdata = 32'(i); cmd_strb = 4'h3; cmd_prot = 3'h1;
            if (cmd_ready) acc++;
            step();
        end
        cmd_valid = 1'b0;
        chk("t3_accepted", 64'(acc), 64'd4);
        chk("t3_full", cmd_ready, 1'b0);
        a_pready = 1'b1;
        wait_rsp(10, "t3_rsp");
        chk("t3_ready_again", cmd_ready, 1'b1);
        repeat (5) begin
            step();
            chk("t3_no_issue", a_psel, 1'b0);
        end
        rsp_ready = 1'b1;
        wait_idle(80, "t3_drain");
        chk("t3_rsp_count", 64'(rsp_log.size()), 64'd4);
        if (rsp_log.size() == 4) chk("t3_last_addr", rsp_log[3], 32'h10C);

        // 4: asynchronous reset in ACCESS
        a_pready = 1'b0;
        send(1'b1, 32'h40, 32'h55, 4'h1, 3'h0);
        n = 0;
        while (!a_penable && n < 5) begin
            step();
            n++;
        end
        chk("t4_in_access", a_penable, 1'b1);
        #2;
        a_prst_n = 1'b0;
        #1;
        chk("t4_psel", a_psel, 1'b0);
        chk("t4_penable", a_penable, 1'b0);
        chk("t4_cmd_ready", cmd_ready, 1'b1);
        chk("t4_busy", busy, 1'b0);
        chk("t4_paddr", a_paddr, 32'h0);
        step();
        step();
        a_prst_n = 1'b1;
        step();

`ifdef APB_TIMEOUT_EN
        // 5: timeout abort and sticky block
        rsp_ready = 1'b0; a_pready = 1'b0; a_prdata = 32'hAAAA5555;
        send(1'b0, 32'h50, 32'h0, 4'h0, 3'h0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (rsp_valid) break;
            if (a_penable) n++;
            step();
        end
        chk("t5_access_cycles", 64'(n), 64'd8);
        chk("t5_err", rsp_err, 1'b1);
        chk("t5_rdata", rsp_rdata, 32'h0);
        chk("t5_sticky", tmo_sticky, 1'b1);
        rsp_ready = 1'b1;
        step();
        chk("t5_ready", cmd_ready, 1'b1);
        send(1'b1, 32'h60, 32'h1, 4'hF, 3'h0);
        repeat (6) begin
            step();
            chk("t5_blocked", a_psel, 1'b0);
        end
        chk("t5_busy", busy, 1'b1);
        do_reset();
        step();
`else
        // 5: without timeout an ACCESS waits indefinitely
        rsp_ready = 1'b0; a_pready = 1'b0;
        send(1'b0, 32'h70, 32'h0, 4'h0, 3'h0);
        repeat (20) step();
        chk("t5_still_waiting", a_penable, 1'b1);
        chk("t5_no_rsp", rsp_valid, 1'b0);
        a_pready = 1'b1; a_prdata = 32'hCAFEF00D;
        wait_rsp(5, "t5_rsp");
        chk("t5_rdata", rsp_rdata, 32'hCAFEF00D);
        chk("t5_err", rsp_err, 1'b0);
        chk("t5_sticky", tmo_sticky, 1'b0);
        rsp_ready = 1'b1; a_pready = 1'b0;
        step();
`endif

        // 6: in-order reads with random ready stalls
        rsp_log.delete();
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'(4 * i);
            cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
            a_pready = 1'($urandom_range(0, 1));
            a_prdata = $urandom;
            step();
        end
        cmd_valid = 1'b0;
        wait_idle(200, "t6_drain");
        chk("t6_rsp_count", 64'(rsp_log.size()), 64'd3);
        if (rsp_log.size() == 3) begin
            chk("t6_order0", rsp_log[0], 32'h0);
            chk("t6_order1", rsp_log[1], 32'h4);
            chk("t6_order2", rsp_log[2], 32'h8);
        end

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
